// File: rtl/uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register map,
// STATUS bit positions and state encodings.
package uart_rx_pkg;

  localparam logic [31:0] REG_DATA   = 32'h0;
  localparam logic [31:0] REG_STATUS = 32'h4;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_FERR   = 3;

  // Tick counts (minus one) to the middle of the start bit and to the next bit centre
  localparam logic [3:0] MID_TICK = 4'd7;
  localparam logic [3:0] BIT_TICK = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WAIT,
    ACC_DONE
  } acc_phase_t;

  function automatic logic [31:0] status_word(input logic ferr, input logic ovr,
                                              input logic full, input logic nempty);
    logic [31:0] w;
    w = 32'h0;
    w[STAT_FERR]   = ferr;
    w[STAT_OVR]    = ovr;
    w[STAT_FULL]   = full;
    w[STAT_NEMPTY] = nempty;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; show-ahead head, pointers carry an
// extra wrap bit so full/empty never alias.
module rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       irst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic [AW:0] count;
  logic        do_push;
  logic        do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge irst) begin
    if (!irst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, byte FIFO and a two-cycle
// MWAIT bus interface (DATA at BASE_ADDR, STATUS at BASE_ADDR+4).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0300,
  parameter int          DIVISOR    = 54,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        irst,
  input  logic [31:0] MADDR,
  inout  wire  [31:0] MDATA,
  input  logic        MEN,
  input  logic        MRW,
  inout  wire         MWAIT,
  input  logic        usb_rx
);

  localparam logic [15:0] TICK_RELOAD = 16'(DIVISOR - 1);

  logic [1:0]  sync_q;
  logic        rx_s;
  logic [15:0] tick_cnt;
  logic        tick;

  always_ff @(posedge clk or negedge irst) begin
    if (!irst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], usb_rx};
    end
  end

  assign rx_s = sync_q[1];

  // Free-running: bit timing tolerates the resulting +/-1 tick phase error
  always_ff @(posedge clk or negedge irst) begin
    if (!irst) begin
      tick_cnt <= TICK_RELOAD;
    end else if (tick) begin
      tick_cnt <= TICK_RELOAD;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  assign tick = (tick_cnt == 16'd0);

  rx_state_t  state;
  rx_state_t  state_nxt;
  logic [3:0] tcnt;
  logic [3:0] tcnt_nxt;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_nxt;
  logic [7:0] shift;
  logic [7:0] shift_nxt;
  logic       push_req;
  logic       ferr_set;

  always_ff @(posedge clk or negedge irst) begin
    if (!irst) begin
      state   <= ST_IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push_req    = 1'b0;
    ferr_set    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tcnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tcnt_nxt = tcnt + 4'd1;
          if (tcnt == MID_TICK) begin
            tcnt_nxt    = '0;
            bit_idx_nxt = '0;
            state_nxt   = rx_s ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tcnt_nxt = tcnt + 4'd1;
          if (tcnt == BIT_TICK) begin
            shift_nxt   = {rx_s, shift[7:1]};
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state_nxt = ST_STOP;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          tcnt_nxt = tcnt + 4'd1;
          if (tcnt == BIT_TICK) begin
            if (rx_s) begin
              push_req  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              ferr_set  = 1'b1;
              state_nxt = ST_BREAK;
            end
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       pop_fire;

  rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .irst (irst),
    .push (push_req),
    .pop  (pop_fire),
    .din  (shift),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  logic        addr_data;
  logic        addr_status;
  logic        sel;
  logic        acc_end;
  acc_phase_t  phase;
  logic [31:0] rdata_q;
  logic        pop_arm;
  logic        ovr;
  logic        ferr;
  logic        ovr_set;
  logic        clr_ovr;
  logic        clr_ferr;

  assign addr_data   = (MADDR == BASE_ADDR + REG_DATA);
  assign addr_status = (MADDR == BASE_ADDR + REG_STATUS);
  assign sel         = MEN && (addr_data || addr_status);
  assign acc_end     = sel && (phase == ACC_WAIT);

  // Pop only if the captured read actually carried a byte; a push landing
  // between the two bus cycles must not be consumed unseen.
  assign pop_fire = acc_end && MRW && pop_arm;
  assign clr_ovr  = acc_end && !MRW && addr_status && MDATA[STAT_OVR];
  assign clr_ferr = acc_end && !MRW && addr_status && MDATA[STAT_FERR];
  assign ovr_set  = push_req && fifo_full && !pop_fire;

  always_ff @(posedge clk or negedge irst) begin
    if (!irst) begin
      phase   <= ACC_IDLE;
      rdata_q <= '0;
      pop_arm <= 1'b0;
    end else if (!sel) begin
      phase   <= ACC_IDLE;
      pop_arm <= 1'b0;
    end else begin
      case (phase)
        ACC_IDLE: begin
          phase   <= ACC_WAIT;
          pop_arm <= MRW && addr_data && !fifo_empty;
          if (addr_data) begin
            rdata_q <= {24'h0, fifo_empty ? 8'h00 : fifo_dout};
          end else begin
            rdata_q <= status_word(ferr, ovr, fifo_full, !fifo_empty);
          end
        end
        ACC_WAIT: begin
          phase   <= ACC_DONE;
          pop_arm <= 1'b0;
        end
        default: begin
          phase <= ACC_DONE;
        end
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle
  always_ff @(posedge clk or negedge irst) begin
    if (!irst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~clr_ovr);
      ferr <= ferr_set | (ferr & ~clr_ferr);
    end
  end

  assign MWAIT = sel ? (phase == ACC_IDLE) : 1'bz;
  assign MDATA = (acc_end && MRW) ? rdata_q : 32'bz;

endmodule
